// File: rtl/ram_responder_if.sv
// ram_responder_if: cpu data-port bus between the cpu (master) and the data-memory responder (slave)
interface ram_responder_if #(parameter int ADDR_W = 32);
  logic [31:0] ram_wdata;
  logic [ADDR_W-1:0] ram_waddr;
  logic [1:0] ram_write_type;
  logic ram_write;
  logic ram_read;
  logic [31:0] ram_data;
  logic mem_busy;
  logic mem_done;
  logic mem_err;
  modport master (
    output ram_wdata, ram_waddr, ram_write_type, ram_write, ram_read,
    input ram_data, mem_busy, mem_done, mem_err
  );
  modport slave (
    input ram_wdata, ram_waddr, ram_write_type, ram_write, ram_read,
    output ram_data, mem_busy, mem_done, mem_err
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: wait-stated byte/half/word data memory answering one cpu request at a time
module ram_responder #(
  parameter int ADDR_W = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk_in,
  input logic rst_in,
  ram_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [DEPTH_LOG2+1:0] addr;
  logic [31:0] wdata;
  logic [1:0] wtype;
  logic wr;
  logic [31:0] data_q;
  logic err_q;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic accept, commit, err;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0] off;
  logic [3:0] be;
  logic [31:0] lane;
  logic unused_addr;
  assign unused_addr = ^bus.ram_waddr[ADDR_W-1:DEPTH_LOG2+2];
  assign accept = state == IDLE && (bus.ram_write || bus.ram_read);
  assign commit = state == WAIT && cnt == 4'd0;
  assign idx = addr[DEPTH_LOG2+1:2];
  assign off = addr[1:0];
  assign err = wr ? (wtype == 2'd3 || (wtype == 2'd1 && off[0]) || (wtype == 2'd2 && off != 2'd0)) : off != 2'd0;
  assign be = wtype == 2'd0 ? 4'b0001 << off : wtype == 2'd1 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lane = wtype == 2'd0 ? {4{wdata[7:0]}} : wtype == 2'd1 ? {2{wdata[15:0]}} : wdata;
  assign bus.mem_busy = state != IDLE;
  assign bus.mem_done = state == RESP;
  assign bus.mem_err = err_q;
  assign bus.ram_data = data_q;
  // next state: accept in IDLE, count wait states, then a single response cycle
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (accept) begin
        state_nx = WAIT;
        cnt_nx = 4'(WAIT_CYCLES);
      end
      WAIT: if (cnt == 4'd0) state_nx = RESP;
      else cnt_nx = cnt - 4'd1;
      default: state_nx = IDLE;
    endcase
  end
  // control state, latched request and the response registers that are only non-zero in RESP
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      wtype <= '0;
      wr <= 1'b0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        addr <= bus.ram_waddr[DEPTH_LOG2+1:0];
        wdata <= bus.ram_wdata;
        wtype <= bus.ram_write_type;
        wr <= bus.ram_write;
      end
      data_q <= commit && !wr && !err ? mem[idx] : '0;
      err_q <= commit && err;
    end
  end
  // byte-lane write into the word array on the edge entering RESP; contents survive reset
  always_ff @(posedge clk_in) begin
    if (commit && wr && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= lane[8*i +: 8];
  end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: randomized scoreboard bench for ram_responder against a word-array reference model
module tb_ram_responder;
  localparam int W = 2;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;
  ram_responder_if #(.ADDR_W(32)) bus();
  ram_responder #(.ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );
  typedef struct {
    logic wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0] t;
    int acc;
  } req_t;
  req_t q[$];
  logic [31:0] mdl [1024];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask
  // monitor: every falling edge check busy, idle outputs, and score each completion
  always @(negedge clk_in) begin
    req_t r;
    logic [31:0] ed;
    logic ee;
    int w;
    int o;
    cyc++;
    if (rst_in) begin
      chk("busy", 32'(bus.mem_busy), 32'(q.size() != 0));
      if (bus.mem_done) begin
        if (q.size() == 0) chk("spurious_done", 32'(bus.mem_done), 32'd0);
        else begin
          r = q.pop_front();
          w = int'(r.a[11:2]);
          ed = 32'd0;
          if (r.wr) begin
            ee = r.t == 2'd3 || (r.t == 2'd1 && r.a[0]) || (r.t == 2'd2 && r.a[1:0] != 2'd0);
            if (!ee) begin
              if (r.t == 2'd0) begin
                o = 8 * int'(r.a[1:0]);
                mdl[w][o +: 8] = r.d[7:0];
              end else if (r.t == 2'd1) begin
                o = 16 * int'(r.a[1]);
                mdl[w][o +: 16] = r.d[15:0];
              end else mdl[w] = r.d;
            end
          end else begin
            ee = r.a[1:0] != 2'd0;
            if (!ee) ed = mdl[w];
          end
          chk("resp_data", bus.ram_data, ed);
          chk("resp_err", 32'(bus.mem_err), 32'(ee));
          chk("latency", 32'(cyc - r.acc), 32'(W + 1));
        end
      end else begin
        chk("idle_data", bus.ram_data, 32'd0);
        chk("idle_err", 32'(bus.mem_err), 32'd0);
      end
    end
  end
  task automatic issue(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    int n = 0;
    @(negedge clk_in);
    while (bus.mem_busy && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    bus.ram_write = wr;
    bus.ram_read = rd;
    bus.ram_waddr = a;
    bus.ram_wdata = d;
    bus.ram_write_type = t;
    @(posedge clk_in);
    q.push_back('{wr, a, d, t, cyc + 1});
    #1;
    bus.ram_write = 1'b0;
    bus.ram_read = 1'b0;
    bus.ram_wdata = $urandom();
    bus.ram_waddr = $urandom();
  endtask
  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (q.size() != 0) begin
      chk("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask
  task automatic run(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    issue(wr, rd, a, d, t);
    wait_idle();
  endtask
  initial begin
    logic wr;
    logic rd;
    bus.ram_write = 1'b0;
    bus.ram_read = 1'b0;
    bus.ram_wdata = '0;
    bus.ram_waddr = '0;
    bus.ram_write_type = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", 32'(bus.mem_busy), 32'd0);
    chk("rst_done", 32'(bus.mem_done), 32'd0);
    chk("rst_err", 32'(bus.mem_err), 32'd0);
    chk("rst_data", bus.ram_data, 32'd0);
    #2 rst_in = 1'b1;
    run(1, 0, 32'h10, 32'hDEADBEEF, 2'd2);
    run(0, 1, 32'h10, 32'h0, 2'd2);
    run(1, 0, 32'h0, 32'h0, 2'd2);
    run(1, 0, 32'h1, 32'hAA, 2'd0);
    run(1, 0, 32'h3, 32'hBB, 2'd0);
    run(1, 0, 32'h0, 32'h1234, 2'd1);
    run(0, 1, 32'h0, 32'h0, 2'd0);
    chk("lane_merge", mdl[0], 32'hBB001234);
    run(1, 0, 32'h3, 32'hFFFF, 2'd1);
    run(0, 1, 32'h2, 32'h0, 2'd2);
    run(1, 0, 32'h4, 32'hFFFFFFFF, 2'd3);
    run(0, 1, 32'h0, 32'h0, 2'd2);
    run(0, 1, 32'h4, 32'h0, 2'd2);
    run(1, 1, 32'h20, 32'h55, 2'd2);
    run(0, 1, 32'h20, 32'h0, 2'd2);
    run(1, 0, 32'h40, 32'h11111111, 2'd2);
    issue(1, 0, 32'h40, 32'h1, 2'd2);
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.mem_busy), 32'd0);
    chk("abort_done", 32'(bus.mem_done), 32'd0);
    chk("abort_data", bus.ram_data, 32'd0);
    q.delete();
    repeat (2) @(negedge clk_in);
    #2 rst_in = 1'b1;
    run(0, 1, 32'h40, 32'h0, 2'd2);
    run(1, 0, 32'h1000, 32'hCAFEF00D, 2'd2);
    run(0, 1, 32'h0, 32'h0, 2'd2);
    chk("alias", mdl[0], 32'hCAFEF00D);
    for (int i = 0; i < 16; i++) run(1, 0, 32'(4 * i), $urandom(), 2'd2);
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = !wr || $urandom_range(0, 3) == 0;
      run(wr, rd, $urandom() & 32'hFFFFF03F, $urandom(), 2'($urandom_range(0, 3)));
    end
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
